// File: rtl/sme_feeder.sv
// Upstream feeder for the string match engine: buffers one tagged host job and
// replays it as back-to-back string strobes, then pattern strobes, then waits for the result.
module sme_feeder #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_tag,
    output logic [DW-1:0] chardata,
    output logic          isstring,
    output logic          ispattern,
    input  logic          sme_valid,
    output logic          busy,
    output logic          err
);
    localparam int SCW = $clog2(STR_MAX + 1);
    localparam int SAW = $clog2(STR_MAX);
    localparam int PCW = $clog2(PAT_MAX + 1);
    localparam int PAW = $clog2(PAT_MAX);

    localparam logic [1:0] TAG_STR = 2'd0;
    localparam logic [1:0] TAG_PAT = 2'd1;
    localparam logic [1:0] TAG_EOJ = 2'd2;

    typedef enum logic [2:0] {IDLE, LOAD, SEND_STR, SEND_PAT, WAIT_RES} state_t;

    state_t state, state_d;

    logic [DW-1:0]  str_buf [STR_MAX];
    logic [DW-1:0]  pat_buf [PAT_MAX];
    logic [SCW-1:0] scnt, slen, idx, sc_eff, rd_idx, pcnt_ext;
    logic [PCW-1:0] pcnt, pc_eff;
    logic           accept, str_full, pat_full, job_bad;
    logic           in_ready_d, busy_d, err_d, isstring_d, ispattern_d;
    logic [DW-1:0]  chardata_d;

    assign accept   = in_valid & in_ready;
    // The first byte of a job sees empty counters regardless of what the last job left.
    assign sc_eff   = (state == IDLE) ? '0 : scnt;
    assign pc_eff   = (state == IDLE) ? '0 : pcnt;
    assign str_full = (sc_eff == SCW'(STR_MAX));
    assign pat_full = (pc_eff == PCW'(PAT_MAX));
    assign job_bad  = (pc_eff == '0) || ((sc_eff == '0) && (slen == '0));
    assign pcnt_ext = SCW'(pcnt);
    // idx counts chars already sent in the current send state; a new send state starts at 0.
    assign rd_idx   = (state_d == state) ? idx : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (in_tag != TAG_EOJ) state_d = LOAD;
                    else if (job_bad)      state_d = IDLE;
                    else if (sc_eff != '0) state_d = SEND_STR;
                    else                   state_d = SEND_PAT;
                end
            end
            SEND_STR: if (idx == slen)     state_d = SEND_PAT;
            SEND_PAT: if (idx == pcnt_ext) state_d = WAIT_RES;
            WAIT_RES: if (sme_valid)       state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Outputs are registered, so this computes their values for the coming state.
    always_comb begin
        in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
        busy_d      = !in_ready_d;
        isstring_d  = (state_d == SEND_STR);
        ispattern_d = (state_d == SEND_PAT);
        chardata_d  = '0;
        if (isstring_d)       chardata_d = str_buf[rd_idx[SAW-1:0]];
        else if (ispattern_d) chardata_d = pat_buf[rd_idx[PAW-1:0]];

        err_d = err;
        if (accept) begin
            if (state == IDLE) err_d = 1'b0;
            case (in_tag)
                TAG_STR: if (str_full) err_d = 1'b1;
                TAG_PAT: if (pat_full) err_d = 1'b1;
                TAG_EOJ: if (job_bad)  err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            chardata  <= '0;
        end else begin
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            err       <= err_d;
            isstring  <= isstring_d;
            ispattern <= ispattern_d;
            chardata  <= chardata_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scnt <= '0;
            pcnt <= '0;
            slen <= '0;
            idx  <= '0;
        end else begin
            idx <= (isstring_d || ispattern_d) ? rd_idx + SCW'(1) : '0;
            if (accept) begin
                scnt <= sc_eff;
                pcnt <= pc_eff;
                case (in_tag)
                    TAG_STR: if (!str_full) scnt <= sc_eff + SCW'(1);
                    TAG_PAT: if (!pat_full) pcnt <= pc_eff + PCW'(1);
                    TAG_EOJ: if (state_d == SEND_STR) slen <= sc_eff;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the char buffers are deliberately not reset; slen/pcnt decide what is valid.
    always_ff @(posedge clk) begin
        if (accept && (in_tag == TAG_STR) && !str_full) str_buf[sc_eff[SAW-1:0]] <= in_data;
        if (accept && (in_tag == TAG_PAT) && !pat_full) pat_buf[pc_eff[PAW-1:0]] <= in_data;
    end

endmodule

// File: tb/tb_sme_feeder.sv
// Self-checking bench for sme_feeder: a job-level queue model checked every cycle,
// plus directed jobs with hand-computed strobe sequences.
module tb_sme_feeder;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_tag;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       sme_valid;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    sme_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .chardata  (chardata),
        .isstring  (isstring),
        .ispattern (ispattern),
        .sme_valid (sme_valid),
        .busy      (busy),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: an accepted end-of-job turns into a queue of strobes that
    // play out one per cycle, followed by a wait for the engine result.
    typedef struct packed {
        logic       is_str;
        logic [7:0] ch;
    } strobe_t;

    strobe_t    m_q[$];
    logic [7:0] m_store[32];
    logic [7:0] m_pat[$];
    int         m_slen, m_scnt;
    bit         m_loading, m_active, m_ready, m_busy, m_err, m_isstr, m_ispat;
    logic [7:0] m_data;
    logic [7:0] seen_s[$];
    logic [7:0] seen_p[$];

    always @(negedge clk) begin : model_compare
        bit      in_wait;
        strobe_t s;
        if (reset) begin
            m_q.delete();
            m_pat.delete();
            m_slen = 0; m_scnt = 0;
            m_loading = 0; m_active = 0; m_ready = 0; m_busy = 0; m_err = 0;
            m_isstr = 0; m_ispat = 0; m_data = 8'h00;
        end
        check("in_ready", in_ready, m_ready);
        check("busy", busy, m_busy);
        check("err", err, m_err);
        check("isstring", isstring, m_isstr);
        check("ispattern", ispattern, m_ispat);
        check("chardata", chardata, m_data);
        if (isstring)  seen_s.push_back(chardata);
        if (ispattern) seen_p.push_back(chardata);

        if (!reset) begin
            in_wait = m_active && !m_isstr && !m_ispat;
            if (m_ready && in_valid) begin
                if (!m_loading) begin
                    m_loading = 1; m_err = 0; m_scnt = 0; m_pat.delete();
                end
                case (in_tag)
                    2'd0: begin
                        if (m_scnt == 32) m_err = 1;
                        else begin m_store[m_scnt] = in_data; m_scnt++; end
                    end
                    2'd1: begin
                        if (m_pat.size() == 8) m_err = 1;
                        else m_pat.push_back(in_data);
                    end
                    2'd2: begin
                        m_loading = 0;
                        if (m_pat.size() == 0 || (m_scnt == 0 && m_slen == 0)) m_err = 1;
                        else begin
                            if (m_scnt != 0) begin
                                m_slen = m_scnt;
                                for (int i = 0; i < m_slen; i++) m_q.push_back({1'b1, m_store[i]});
                            end
                            foreach (m_pat[i]) m_q.push_back({1'b0, m_pat[i]});
                            m_active = 1;
                        end
                    end
                    default: ;
                endcase
            end
            if (in_wait && sme_valid) m_active = 0;
            if (m_q.size() > 0) begin
                s = m_q.pop_front();
                m_isstr = s.is_str; m_ispat = !s.is_str; m_data = s.ch;
            end else begin
                m_isstr = 0; m_ispat = 0; m_data = 8'h00;
            end
            m_busy  = m_active;
            m_ready = !m_active;
        end
    end

    task automatic send(input logic [1:0] tag, input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1; in_tag = tag; in_data = d;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("send_ready", in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_chars(input logic [1:0] tag, input string txt);
        for (int i = 0; i < txt.len(); i++) send(tag, txt[i]);
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_tag = 2'd0; in_data = 8'h00;
    endtask

    task automatic finish_job();
        int n = 0;
        @(negedge clk);
        while (!(busy && !isstring && !ispattern) && n < 200) begin @(negedge clk); n++; end
        check("reach_wait", busy && !isstring && !ispattern, 1);
        @(posedge clk); #1 sme_valid = 1'b1;
        @(posedge clk); #1 sme_valid = 1'b0;
        check("ready_after_result", in_ready, 1);
        check("busy_after_result", busy, 0);
    endtask

    logic [7:0] exp_basic_s[4] = '{8'h61, 8'h62, 8'h20, 8'h63};
    logic [7:0] exp_basic_p[2] = '{8'h62, 8'h2E};
    logic [7:0] exp_reuse_p[2] = '{8'h5E, 8'h63};

    initial begin
        reset = 1'b1; sme_valid = 1'b0;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_strobes", {isstring, ispattern, busy, err}, 4'b0000);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", in_ready, 1);

        // basic job: "ab c" / "b."
        seen_s.delete(); seen_p.delete();
        send_chars(2'd0, "ab c");
        send_chars(2'd1, "b.");
        send(2'd2, 8'h00);
        check("basic_first_isstring", isstring, 1);
        check("basic_first_char", chardata, 8'h61);
        check("basic_ready_low", in_ready, 0);
        idle_in();
        finish_job();
        check("basic_nstr", seen_s.size(), 4);
        check("basic_npat", seen_p.size(), 2);
        for (int i = 0; i < 4; i++) if (i < seen_s.size()) check("basic_str_char", seen_s[i], exp_basic_s[i]);
        for (int i = 0; i < 2; i++) if (i < seen_p.size()) check("basic_pat_char", seen_p[i], exp_basic_p[i]);

        // reuse the stored string, with a stray sme_valid during the send
        seen_s.delete(); seen_p.delete();
        send_chars(2'd1, "^c");
        send(2'd2, 8'h00);
        check("reuse_first_ispattern", ispattern, 1);
        check("reuse_first_char", chardata, 8'h5E);
        check("reuse_no_isstring", isstring, 0);
        check("reuse_err", err, 0);
        idle_in();
        sme_valid = 1'b1;
        @(posedge clk); #1 sme_valid = 1'b0;
        finish_job();
        check("reuse_nstr", seen_s.size(), 0);
        check("reuse_npat", seen_p.size(), 2);
        for (int i = 0; i < 2; i++) if (i < seen_p.size()) check("reuse_pat_char", seen_p[i], exp_reuse_p[i]);

        // overflow, then a held ignored byte as backpressure
        seen_s.delete(); seen_p.delete();
        for (int i = 0; i < 34; i++) send(2'd0, 8'h41 + 8'(i % 26));
        for (int i = 0; i < 9; i++) send(2'd1, 8'h30 + 8'(i));
        send(2'd2, 8'h00);
        check("ovf_err", err, 1);
        in_tag = 2'd3; in_data = 8'h55;
        check("ovf_ready_low", in_ready, 0);
        finish_job();
        check("ovf_err_held", err, 1);
        @(posedge clk); #1;
        check("held_byte_clears_err", err, 0);
        check("held_byte_ready", in_ready, 1);
        idle_in();
        check("ovf_nstr", seen_s.size(), 32);
        check("ovf_npat", seen_p.size(), 8);
        if (seen_s.size() == 32) check("ovf_last_str", seen_s[31], 8'h46);
        if (seen_p.size() == 8) check("ovf_last_pat", seen_p[7], 8'h37);

        // empty pattern
        seen_s.delete(); seen_p.delete();
        send_chars(2'd0, "xy");
        send(2'd2, 8'h00);
        idle_in();
        check("empty_pat_err", err, 1);
        check("empty_pat_ready", in_ready, 1);
        check("empty_pat_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        check("empty_pat_nstrobes", seen_s.size() + seen_p.size(), 0);

        // reset during the third string char
        send_chars(2'd0, "hello");
        send_chars(2'd1, "l");
        send(2'd2, 8'h00);
        idle_in();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("third_char", chardata, 8'h6C);
        reset = 1'b1;
        #1;
        check("midrst_outputs", {in_ready, isstring, ispattern, busy, err}, 5'b00000);
        check("midrst_chardata", chardata, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", in_ready, 1);

        // pattern-only job after reset has no string to reuse
        seen_s.delete(); seen_p.delete();
        send(2'd1, 8'h61);
        send(2'd2, 8'h00);
        idle_in();
        check("lost_str_err", err, 1);
        check("lost_str_busy", busy, 0);
        check("lost_str_ispattern", ispattern, 0);
        repeat (4) @(posedge clk);
        #1;
        check("lost_str_nstrobes", seen_s.size() + seen_p.size(), 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sme_feeder.md
Name: sme_feeder

Overview:
- Upstream stage of the string match engine.
- Accepts a tagged byte stream from the host over a valid/ready handshake and buffers one job: up to 32 string chars plus up to 8 pattern chars.
- Replays the job to the match engine as back-to-back isstring strobes, then back-to-back ispattern strobes.
- Holds off the next job until the engine returns valid.

Parameters:
- STR_MAX, 32, string buffer depth in chars.
- PAT_MAX, 8, pattern buffer depth in chars.
- DW, 8, character width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  host byte valid
- in_ready  output  1  feeder accepts a byte this cycle
- in_data  input  DW  host byte
- in_tag  input  2  0 = string char, 1 = pattern char, 2 = end-of-job, 3 = ignored (consumed, no effect)
- chardata  output  DW  char to match engine
- isstring  output  1  chardata is a string char
- ispattern  output  1  chardata is a pattern char
- sme_valid  input  1  match engine result valid (1-cycle pulse)
- busy  output  1  a job is sending or awaiting its result
- err  output  1  sticky job error flag

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - in_ready = 0; chardata = 0; isstring = 0; ispattern = 0; busy = 0; err = 0.
  - Stored string length = 0; pattern length = 0; state = IDLE.
  - in_ready rises on the first clock edge after reset deasserts.
- A handshake occurs on a rising edge with in_valid & in_ready.
- All outputs are registered.
- States:
  - IDLE:
    - in_ready = 1.
    - The first accepted byte clears err, clears the new-string and pattern counters, then behaves as in LOAD. Next state is LOAD.
    - An accepted end-of-job byte in IDLE is handled as the LOAD end-of-job case.
  - LOAD:
    - in_ready = 1.
    - Tag 0 writes str_buf[scnt] and increments scnt. Tag 1 writes pat_buf[pcnt] and increments pcnt.
    - A char arriving when its counter equals its MAX is dropped and sets err. The counter saturates.
    - On end-of-job:
      - If pcnt == 0: discard the job, set err, go to IDLE.
      - If scnt == 0 and the stored string length == 0: discard the job, set err, go to IDLE.
      - If scnt == 0 and the stored string length != 0: reuse the previous string, go to SEND_PAT.
      - Otherwise: latch the stored string length = scnt and go to SEND_STR.
    - New string chars overwrite the stored string in place. A job whose string is discarded therefore leaves it corrupted; the host must resend a string after any err.
  - SEND_STR:
    - in_ready = 0; busy = 1.
    - Drives one string char per cycle with isstring = 1, indices 0..len-1.
    - After the last char, goes directly to SEND_PAT with no idle gap.
  - SEND_PAT:
    - in_ready = 0; busy = 1.
    - Drives one pattern char per cycle with ispattern = 1, indices 0..pcnt-1.
    - Then goes to WAIT_RES.
  - WAIT_RES:
    - isstring = ispattern = 0; busy = 1; in_ready = 0.
    - On sme_valid, goes to IDLE. in_ready is 1 in the following cycle.
- Timing:
  - The first isstring (or ispattern on reuse) is visible in the cycle immediately after the end-of-job handshake edge.
  - isstring and ispattern are never high together.
  - chardata = 0 whenever both strobes are low.
- sme_valid outside WAIT_RES is ignored.
- Characters are passed through unmodified, including ^ $ . and space.
- Reset mid-operation:
  - Strobes drop immediately and all state returns to reset values.
  - The stored string is lost, so a subsequent reuse job errors.

Test Plan:
- Basic job: send "ab c", pattern "b.", end-of-job.
  -> Next cycle onward: isstring for 4 cycles with 0x61, 0x62, 0x20, 0x63, then ispattern for 2 cycles with 0x62, 0x2E, then busy = 1 until sme_valid. in_ready = 1 one cycle after sme_valid.
- Reuse: after the basic job, send pattern "^c" with no string chars.
  -> No isstring pulses; ispattern 0x5E, 0x63 back-to-back; err = 0.
- Overflow: 34 string chars, 9 pattern chars, end-of-job.
  -> Exactly 32 isstring and 8 ispattern pulses; err = 1 until the next job's first byte.
- Empty pattern: string "xy" then end-of-job with no pattern chars.
  -> No strobes; err = 1; in_ready stays 1.
- Backpressure: hold in_valid = 1 during SEND/WAIT.
  -> in_ready = 0 and no bytes consumed; the held byte is accepted in the first cycle after sme_valid returns to IDLE.
- Reset mid-send: assert reset during the 3rd isstring cycle.
  -> All outputs 0 immediately. A subsequent pattern-only job sets err = 1 with no strobes.
